// File: rtl/vtl_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vtl_mem_arbiter
// Purpose  : Shares the SDRAM byte port between VTL video fetch (fixed
//            priority) and the Z80 CPU, with 16K bank translation.
// Revision : 1.0
// ============================================================================
module vtl_mem_arbiter #(
  parameter int          ACC_CYC    = 3,
  parameter logic [24:0] VIDEO_BASE = 25'h1C000
) (
  input  logic        F14M,
  input  logic        RESET,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic [7:0]  vid_data,
  output logic        vid_valid,
  output logic        vid_ovf,
  input  logic        MREQ_n,
  input  logic        RD_n,
  input  logic        WR_n,
  input  logic [15:0] A,
  input  logic [7:0]  DO,
  output logic [7:0]  DI,
  output logic        WAIT_n,
  input  logic        bank_wr,
  input  logic [1:0]  bank_sel,
  input  logic [3:0]  bank_val,
  output logic [24:0] sdram_addr,
  output logic [7:0]  sdram_din,
  input  logic [7:0]  sdram_dout,
  output logic        sdram_wr,
  output logic        sdram_cs
);

  localparam int                  c_cnt_w    = $clog2(ACC_CYC);
  localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(ACC_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VID  = 2'd1,
    ST_CPU  = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [3:0]         r_bank [4];
  logic               r_vid_pend;
  logic [13:0]        r_vid_addr;
  logic               r_cpu_pend;
  logic               r_cpu_done;
  logic               r_cpu_rd;

  logic        w_cpu_req;
  logic [3:0]  w_cpu_page;
  logic [24:0] w_cpu_addr;
  logic        w_cpu_wr;
  logic [24:0] w_vid_phys;
  logic        w_last;
  logic        w_done_vid;
  logic        w_done_cpu;
  logic        w_grant_vid;
  logic        w_grant_cpu;

  assign w_cpu_req  = !MREQ_n && (!RD_n || !WR_n);
  assign w_cpu_page = r_bank[A[15:14]];
  assign w_cpu_addr = {7'd0, w_cpu_page, A[13:0]};
  // Pages 0-3 are ROM: the access still runs, but never writes.
  assign w_cpu_wr   = !WR_n && (w_cpu_page[3:2] != 2'b00);
  assign w_vid_phys = VIDEO_BASE | {11'd0, r_vid_addr};
  assign w_last     = (r_cnt == c_cnt_last);
  assign w_done_vid = (r_state == ST_VID) && w_last;
  assign w_done_cpu = (r_state == ST_CPU) && w_last;
  assign WAIT_n     = !(r_cpu_pend && !r_cpu_done);

  // Grants happen from IDLE or chained off the last cycle of an access.
  always_comb begin
    w_grant_vid = 1'b0;
    w_grant_cpu = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant_vid = r_vid_pend;
        w_grant_cpu = !r_vid_pend && r_cpu_pend;
      end
      ST_VID:  w_grant_cpu = w_last && r_cpu_pend;
      ST_CPU:  w_grant_vid = w_last && r_vid_pend;
      default: ;
    endcase
  end

  always_ff @(posedge F14M or posedge RESET) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bank[0]  <= 4'd0;
      r_bank[1]  <= 4'd1;
      r_bank[2]  <= 4'd2;
      r_bank[3]  <= 4'd3;
      r_vid_pend <= 1'b0;
      r_vid_addr <= 14'd0;
      r_cpu_pend <= 1'b0;
      r_cpu_done <= 1'b0;
      r_cpu_rd   <= 1'b0;
      vid_data   <= 8'd0;
      vid_valid  <= 1'b0;
      vid_ovf    <= 1'b0;
      DI         <= 8'd0;
      sdram_addr <= 25'd0;
      sdram_din  <= 8'd0;
      sdram_wr   <= 1'b0;
      sdram_cs   <= 1'b0;
    end else begin
      vid_valid <= 1'b0;

      if (bank_wr)
        r_bank[bank_sel] <= bank_val;

      if (vid_req) begin
        if (r_vid_pend) begin
          vid_ovf <= 1'b1;
        end else begin
          r_vid_pend <= 1'b1;
          r_vid_addr <= vid_addr;
        end
      end

      if (w_cpu_req && !r_cpu_done)
        r_cpu_pend <= 1'b1;
      if (MREQ_n)
        r_cpu_done <= 1'b0;

      if (r_state != ST_IDLE)
        r_cnt <= r_cnt + 1'b1;

      if (w_last && (r_state != ST_IDLE)) begin
        r_state  <= ST_IDLE;
        r_cnt    <= '0;
        sdram_cs <= 1'b0;
        sdram_wr <= 1'b0;
      end

      if (w_done_vid) begin
        vid_data   <= sdram_dout;
        vid_valid  <= 1'b1;
        r_vid_pend <= 1'b0;
      end

      if (w_done_cpu) begin
        if (r_cpu_rd)
          DI <= sdram_dout;
        r_cpu_pend <= 1'b0;
        r_cpu_done <= 1'b1;
      end

      if (w_grant_vid) begin
        r_state    <= ST_VID;
        r_cnt      <= '0;
        sdram_addr <= w_vid_phys;
        sdram_wr   <= 1'b0;
        sdram_cs   <= 1'b1;
      end else if (w_grant_cpu) begin
        r_state    <= ST_CPU;
        r_cnt      <= '0;
        sdram_addr <= w_cpu_addr;
        sdram_din  <= DO;
        sdram_wr   <= w_cpu_wr;
        r_cpu_rd   <= WR_n;
        sdram_cs   <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vtl_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vtl_mem_arbiter
// Purpose  : Directed self-checking bench for vtl_mem_arbiter.
// Revision : 1.0
// ============================================================================
module tb_vtl_mem_arbiter;

  logic        F14M = 1'b0;
  logic        RESET;
  logic        vid_req;
  logic [13:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        vid_ovf;
  logic        MREQ_n;
  logic        RD_n;
  logic        WR_n;
  logic [15:0] A;
  logic [7:0]  DO;
  logic [7:0]  DI;
  logic        WAIT_n;
  logic        bank_wr;
  logic [1:0]  bank_sel;
  logic [3:0]  bank_val;
  logic [24:0] sdram_addr;
  logic [7:0]  sdram_din;
  logic [7:0]  sdram_dout;
  logic        sdram_wr;
  logic        sdram_cs;

  int vectors     = 0;
  int miscompares = 0;

  always #5 F14M = ~F14M;

  // SDRAM stub: byte returned is the low address byte XOR 8'hA5.
  assign sdram_dout = sdram_addr[7:0] ^ 8'hA5;

  vtl_mem_arbiter dut (
    .F14M(F14M), .RESET(RESET),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_ovf(vid_ovf),
    .MREQ_n(MREQ_n), .RD_n(RD_n), .WR_n(WR_n), .A(A), .DO(DO), .DI(DI),
    .WAIT_n(WAIT_n),
    .bank_wr(bank_wr), .bank_sel(bank_sel), .bank_val(bank_val),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_dout(sdram_dout),
    .sdram_wr(sdram_wr), .sdram_cs(sdram_cs)
  );

  task automatic tick();
    @(posedge F14M);
    @(negedge F14M);
  endtask

  task automatic cpu_idle();
    MREQ_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; vid_req = 1'b0; vid_addr = '0; A = '0; DO = '0;
    bank_wr = 1'b0; bank_sel = '0; bank_val = '0;
    cpu_idle();
    tick(); tick();
    vectors++;
    if ({sdram_cs, sdram_wr, vid_valid, vid_ovf, WAIT_n} !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_ctl: got cs/wr/vv/ovf/wait=%b want 00001",
               {sdram_cs, sdram_wr, vid_valid, vid_ovf, WAIT_n});
    end
    vectors++;
    if ({sdram_addr, sdram_din, DI, vid_data} !== 49'd0) begin
      miscompares++;
      $display("FAIL reset_data: got addr=%h din=%h DI=%h vd=%h want all 0",
               sdram_addr, sdram_din, DI, vid_data);
    end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read();
    int cs_cnt = 0;
    A = 16'h4005; MREQ_n = 1'b0; RD_n = 1'b0;
    tick();
    vectors++;
    if (WAIT_n !== 1'b0 || sdram_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_pend: got wait=%b cs=%b want 0 0", WAIT_n, sdram_cs);
    end
    tick();
    vectors++;
    if (sdram_addr !== 25'h04005 || sdram_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_addr: got addr=%h wr=%b want 04005 0", sdram_addr, sdram_wr);
    end
    for (int i = 0; i < 6; i++) begin
      if (sdram_cs === 1'b1) cs_cnt++;
      if (i < 5) tick();
      if (i == 2) begin
        vectors++;
        if (DI !== 8'hA0 || WAIT_n !== 1'b1) begin
          miscompares++;
          $display("FAIL rd_done: got DI=%h wait=%b want a0 1", DI, WAIT_n);
        end
        cpu_idle();
      end
    end
    vectors++;
    if (cs_cnt != 3) begin
      miscompares++;
      $display("FAIL rd_cs_len: got %0d cycles want 3", cs_cnt);
    end
  endtask

  task automatic test_bank_write();
    bank_wr = 1'b1; bank_sel = 2'd3; bank_val = 4'd7;
    tick();
    bank_wr = 1'b0;
    A = 16'hC010; DO = 8'h5A; MREQ_n = 1'b0; WR_n = 1'b0;
    tick(); tick();
    vectors++;
    if (sdram_cs !== 1'b1 || sdram_addr !== 25'h1C010 || sdram_wr !== 1'b1 ||
        sdram_din !== 8'h5A) begin
      miscompares++;
      $display("FAIL bank_wr: got cs=%b addr=%h wr=%b din=%h want 1 1c010 1 5a",
               sdram_cs, sdram_addr, sdram_wr, sdram_din);
    end
    tick(); tick(); tick();
    vectors++;
    if (sdram_cs !== 1'b0 || WAIT_n !== 1'b1 || DI !== 8'hA0) begin
      miscompares++;
      $display("FAIL wr_done: got cs=%b wait=%b DI=%h want 0 1 a0", sdram_cs, WAIT_n, DI);
    end
    cpu_idle();
    tick();
  endtask

  task automatic test_rom_write();
    int wr_seen = 0;
    A = 16'h0100; DO = 8'h33; MREQ_n = 1'b0; WR_n = 1'b0;
    tick(); tick();
    vectors++;
    if (sdram_cs !== 1'b1 || sdram_addr !== 25'h00100) begin
      miscompares++;
      $display("FAIL rom_addr: got cs=%b addr=%h want 1 00100", sdram_cs, sdram_addr);
    end
    for (int i = 0; i < 3; i++) begin
      if (sdram_wr !== 1'b0) wr_seen++;
      tick();
    end
    vectors++;
    if (wr_seen != 0 || sdram_cs !== 1'b0 || WAIT_n !== 1'b1 || DI !== 8'hA0) begin
      miscompares++;
      $display("FAIL rom_wr: got wr_cycles=%0d cs=%b wait=%b DI=%h want 0 0 1 a0",
               wr_seen, sdram_cs, WAIT_n, DI);
    end
    cpu_idle();
    tick();
  endtask

  task automatic test_tie();
    vid_req = 1'b1; vid_addr = 14'h0123;
    A = 16'h8077; MREQ_n = 1'b0; RD_n = 1'b0;
    tick();
    vid_req = 1'b0;
    tick();
    vectors++;
    if (sdram_cs !== 1'b1 || sdram_addr !== 25'h1C123 || WAIT_n !== 1'b0) begin
      miscompares++;
      $display("FAIL tie_vid: got cs=%b addr=%h wait=%b want 1 1c123 0",
               sdram_cs, sdram_addr, WAIT_n);
    end
    tick(); tick(); tick();
    vectors++;
    if (vid_valid !== 1'b1 || vid_data !== 8'h86 || sdram_cs !== 1'b1 ||
        sdram_addr !== 25'h08077) begin
      miscompares++;
      $display("FAIL tie_chain: got vv=%b vd=%h cs=%b addr=%h want 1 86 1 08077",
               vid_valid, vid_data, sdram_cs, sdram_addr);
    end
    tick(); tick(); tick();
    vectors++;
    if (DI !== 8'hD2 || WAIT_n !== 1'b1 || sdram_cs !== 1'b0 || vid_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL tie_cpu: got DI=%h wait=%b cs=%b vv=%b want d2 1 0 0",
               DI, WAIT_n, sdram_cs, vid_valid);
    end
    cpu_idle();
    tick();
  endtask

  task automatic test_overflow();
    int strobes = 0;
    A = 16'h4005; MREQ_n = 1'b0; RD_n = 1'b0;
    tick(); tick();
    vid_req = 1'b1; vid_addr = 14'h0010;
    tick();
    vid_req = 1'b0;
    tick();
    vid_req = 1'b1; vid_addr = 14'h0020;
    tick();
    vid_req = 1'b0;
    vectors++;
    if (vid_ovf !== 1'b1 || sdram_cs !== 1'b1 || sdram_addr !== 25'h1C010 ||
        WAIT_n !== 1'b1 || DI !== 8'hA0) begin
      miscompares++;
      $display("FAIL ovf_flag: got ovf=%b cs=%b addr=%h wait=%b DI=%h want 1 1 1c010 1 a0",
               vid_ovf, sdram_cs, sdram_addr, WAIT_n, DI);
    end
    cpu_idle();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (vid_valid === 1'b1) begin
        strobes++;
        vectors++;
        if (vid_data !== 8'hB5) begin
          miscompares++;
          $display("FAIL ovf_data: got %h want b5", vid_data);
        end
      end
    end
    vectors++;
    if (strobes != 1 || vid_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_strobes: got %0d strobes ovf=%b want 1 1", strobes, vid_ovf);
    end
  endtask

  task automatic test_reset_mid_access();
    A = 16'hC010; DO = 8'h11; MREQ_n = 1'b0; WR_n = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (sdram_cs !== 1'b1 || sdram_wr !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre: got cs=%b wr=%b want 1 1", sdram_cs, sdram_wr);
    end
    #1 RESET = 1'b1;
    #1;
    vectors++;
    if (sdram_cs !== 1'b0 || sdram_wr !== 1'b0 || WAIT_n !== 1'b1 || vid_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got cs=%b wr=%b wait=%b ovf=%b want 0 0 1 0",
               sdram_cs, sdram_wr, WAIT_n, vid_ovf);
    end
    cpu_idle();
    @(negedge F14M);
    RESET = 1'b0;
    tick();
    vectors++;
    if (vid_valid !== 1'b0 || sdram_cs !== 1'b0 || DI !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_nostrobe: got vv=%b cs=%b DI=%h want 0 0 00", vid_valid, sdram_cs, DI);
    end
    A = 16'hC010; MREQ_n = 1'b0; RD_n = 1'b0;
    tick(); tick();
    vectors++;
    if (sdram_addr !== 25'h0C010 || sdram_cs !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_banks: got addr=%h cs=%b want 0c010 1", sdram_addr, sdram_cs);
    end
    tick(); tick(); tick();
    vectors++;
    if (DI !== 8'hB5 || WAIT_n !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_read: got DI=%h wait=%b want b5 1", DI, WAIT_n);
    end
    cpu_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_bank_write();
    test_rom_write();
    test_tie();
    test_overflow();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
